// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer and the next-PC selection logic.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3
  } state_t;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC select from the control unit's pcsource, word-aligned.
module next_pc_mux
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      pcsource,
  input  logic [PC_W-1:0] pc4,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] jr_target,
  input  logic [PC_W-1:0] j_target,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc4;
    case (pcsource)
      PCS_SEQ: next_pc = pc4;
      PCS_BR:  next_pc = br_target;
      PCS_JR:  next_pc = jr_target;
      PCS_J:   next_pc = j_target;
      default: next_pc = pc4;
    endcase
    // Instructions are word aligned; misaligned targets are silently truncated.
    next_pc[1:0] = 2'b00;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, sequences IROM reads, and applies
// the next-PC selection once per advance, with breakpoint/halt and retire count.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              ROM_AW   = 6,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
  parameter int              ROM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              run,
  input  logic              step,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [1:0]        pcsource,
  input  logic [PC_W-1:0]   br_target,
  input  logic [PC_W-1:0]   jr_target,
  input  logic [PC_W-1:0]   j_target,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc4,
  output logic              halted,
  output logic [2:0]        state_o,
  output logic [15:0]       retired
);

  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  state_t            state, state_nx;
  logic [1:0]        lat_cnt;
  logic              step_q;
  logic              skip;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   next_pc;
  logic [15:0]       retired_q;

  logic step_rise;
  logic adv;
  logic lat_done;
  logic bp_hit;
  logic halt_leave;

  assign step_rise  = step & ~step_q;
  assign adv        = run ? tick : step_rise;
  assign lat_done   = (lat_cnt == LAT_LAST);
  assign halt_leave = step_rise & ~run;
  // Breakpoint compares word addresses only; skip suppresses a re-hit after resuming.
  assign bp_hit     = bp_en && (((next_pc ^ bp_addr) >> 2) == '0) && !skip;
  assign pc4        = pc_q + PC_W'(4);

  next_pc_mux #(.PC_W(PC_W)) u_next_pc_mux (
    .pcsource  (pcsource),
    .pc4       (pc4),
    .br_target (br_target),
    .jr_target (jr_target),
    .j_target  (j_target),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:  state_nx = adv ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_nx = lat_done ? ST_EXEC : ST_FETCH;
      ST_EXEC:  state_nx = bp_hit ? ST_HALT : ST_IDLE;
      ST_HALT:  state_nx = halt_leave ? ST_FETCH : ST_HALT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // inst_valid is a one-cycle strobe: IROM data is valid and control commits
  // exactly in that cycle; there is no backpressure.
  always_comb begin
    rom_en     = (state == ST_FETCH);
    inst_valid = (state == ST_EXEC);
    halted     = (state == ST_HALT);
    rom_addr   = pc_q[ROM_AW+1:2];
    state_o    = state;
    pc         = pc_q;
    retired    = retired_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q    <= 1'b0;
      lat_cnt   <= 2'd0;
      skip      <= 1'b0;
      pc_q      <= RESET_PC;
      retired_q <= 16'd0;
    end else begin
      step_q <= step;
      if (state == ST_FETCH && !lat_done) lat_cnt <= lat_cnt + 2'd1;
      else                                lat_cnt <= 2'd0;
      if (state == ST_HALT && halt_leave) skip <= 1'b1;
      else if (state == ST_EXEC)          skip <= 1'b0;
      if (state == ST_EXEC) begin
        pc_q <= next_pc;
        if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for run-mode sequencing plus
// hand-written step, jump, breakpoint, wrap, saturation and reset sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst, rst3;
  logic        tick, run, step, bp_en;
  logic [31:0] bp_addr, br_target, jr_target, j_target;
  logic [1:0]  pcsource;

  logic        rom_en, inst_valid, halted;
  logic [5:0]  rom_addr;
  logic [31:0] pc, pc4;
  logic [2:0]  state_o;
  logic [15:0] retired;

  logic        rom_en3, inst_valid3, halted3;
  logic [5:0]  rom_addr3;
  logic [31:0] pc3, pc43;
  logic [2:0]  state_o3;
  logic [15:0] retired3;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [15:0] m_ret;

  fetch_sequencer #(.ROM_LAT(1)) dut (
    .clk(clk), .reset(rst), .tick(tick), .run(run), .step(step),
    .bp_en(bp_en), .bp_addr(bp_addr), .pcsource(pcsource),
    .br_target(br_target), .jr_target(jr_target), .j_target(j_target),
    .rom_en(rom_en), .rom_addr(rom_addr), .inst_valid(inst_valid),
    .pc(pc), .pc4(pc4), .halted(halted), .state_o(state_o), .retired(retired)
  );

  fetch_sequencer #(.ROM_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .tick(tick), .run(run), .step(step),
    .bp_en(bp_en), .bp_addr(bp_addr), .pcsource(pcsource),
    .br_target(br_target), .jr_target(jr_target), .j_target(j_target),
    .rom_en(rom_en3), .rom_addr(rom_addr3), .inst_valid(inst_valid3),
    .pc(pc3), .pc4(pc43), .halted(halted3), .state_o(state_o3), .retired(retired3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every commit of the main DUT must match the next expected pc
  always @(negedge clk) begin
    if (!rst && inst_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got pc %0h expected no commit", pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc !== e) begin
          errors++;
          $display("FAIL commit_pc: got %0h expected %0h", pc, e);
        end
      end
    end
  end

  // driver: one instruction via tick (run mode) or step press (step mode)
  task automatic issue(input logic use_step, input logic [1:0] pcs, input logic [31:0] nxt);
    exp_q.push_back(m_pc);
    pcsource = pcs;
    if (use_step) begin run = 1'b0; step = 1'b1; end
    else          begin run = 1'b1; tick = 1'b1; end
    clk1();
    step = 1'b0; tick = 1'b0;
    clk1();
    clk1();
    m_pc = nxt;
    if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
  endtask

  task automatic chk_arch(input string name, input logic [2:0] st);
    chk({name, "_pc"}, pc, m_pc);
    chk({name, "_retired"}, {16'd0, retired}, {16'd0, m_ret});
    chk({name, "_state"}, {29'd0, state_o}, {29'd0, st});
  endtask

  typedef struct {
    logic        run, tick, step;
    logic [2:0]  st;
    logic [31:0] pc;
    logic        rom_en;
    logic [5:0]  addr;
    logic        iv;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[13];

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    tick = 0; run = 0; step = 0; bp_en = 0; bp_addr = 0;
    pcsource = 2'b00; br_target = 0; jr_target = 0; j_target = 0;
    m_pc = 32'h0; m_ret = 16'd0;

    vecs[0]  = '{1, 0, 1, 3'd0, 32'h00, 0, 6'd0, 0, 16'd0};
    vecs[1]  = '{1, 1, 0, 3'd1, 32'h00, 1, 6'd0, 0, 16'd0};
    vecs[2]  = '{1, 0, 0, 3'd2, 32'h00, 0, 6'd0, 1, 16'd0};
    vecs[3]  = '{1, 0, 0, 3'd0, 32'h04, 0, 6'd1, 0, 16'd1};
    vecs[4]  = '{1, 1, 0, 3'd1, 32'h04, 1, 6'd1, 0, 16'd1};
    vecs[5]  = '{1, 1, 0, 3'd2, 32'h04, 0, 6'd1, 1, 16'd1};
    vecs[6]  = '{1, 1, 0, 3'd0, 32'h08, 0, 6'd2, 0, 16'd2};
    vecs[7]  = '{1, 1, 0, 3'd1, 32'h08, 1, 6'd2, 0, 16'd2};
    vecs[8]  = '{1, 0, 0, 3'd2, 32'h08, 0, 6'd2, 1, 16'd2};
    vecs[9]  = '{1, 0, 0, 3'd0, 32'h0C, 0, 6'd3, 0, 16'd3};
    vecs[10] = '{1, 1, 0, 3'd1, 32'h0C, 1, 6'd3, 0, 16'd3};
    vecs[11] = '{1, 0, 0, 3'd2, 32'h0C, 0, 6'd3, 1, 16'd3};
    vecs[12] = '{1, 0, 0, 3'd0, 32'h10, 0, 6'd4, 0, 16'd4};

    // reset state
    repeat (2) clk1();
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h4);
    chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    rst = 1'b0;

    // run mode, sequential pcsource, four ticks
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 13; i++) begin
      run = vecs[i].run; tick = vecs[i].tick; step = vecs[i].step;
      clk1();
      chk($sformatf("vec%0d_state", i), {29'd0, state_o}, {29'd0, vecs[i].st});
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_rom_en", i), {31'd0, rom_en}, {31'd0, vecs[i].rom_en});
      chk($sformatf("vec%0d_rom_addr", i), {26'd0, rom_addr}, {26'd0, vecs[i].addr});
      chk($sformatf("vec%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].iv});
      chk($sformatf("vec%0d_retired", i), {16'd0, retired}, {16'd0, vecs[i].ret});
    end
    tick = 0; step = 0;
    m_pc = 32'h10; m_ret = 16'd4;

    // step held high for many cycles: one commit only
    run = 1'b0;
    exp_q.push_back(m_pc);
    step = 1'b1;
    repeat (10) clk1();
    step = 1'b0;
    clk1();
    m_pc = 32'h14; m_ret = 16'd5;
    chk_arch("step_hold", 3'd0);

    // ticks in step mode do nothing
    repeat (4) begin tick = 1'b1; clk1(); tick = 1'b0; clk1(); end
    chk_arch("tick_in_step", 3'd0);

    // control-flow selection with misaligned targets
    j_target = 32'h0000_0023; issue(0, 2'b11, 32'h20); chk_arch("jump", 3'd0);
    br_target = 32'h8;        issue(0, 2'b01, 32'h08); chk_arch("branch", 3'd0);
    jr_target = 32'h42;       issue(1, 2'b10, 32'h40); chk_arch("jr_step", 3'd0);

    // breakpoint at C (low address bits ignored)
    bp_en = 1'b1; bp_addr = 32'h0000_000E;
    issue(0, 2'b01, 32'h08); chk_arch("bp_pre", 3'd0);
    issue(0, 2'b00, 32'h0C); chk_arch("bp_hit", 3'd3);
    chk("bp_halted", {31'd0, halted}, 32'd1);
    repeat (4) begin run = 1'b1; tick = 1'b1; clk1(); end
    tick = 1'b0;
    step = 1'b1; clk1(); step = 1'b0; clk1(); clk1();
    chk_arch("halt_ignores_run", 3'd3);
    issue(1, 2'b00, 32'h10); chk_arch("bp_resume", 3'd0);
    chk("bp_resume_halted", {31'd0, halted}, 32'd0);

    // resuming onto the breakpoint itself must not re-halt; later hits still halt
    j_target = 32'hC;
    issue(0, 2'b11, 32'h0C); chk_arch("bp_hit2", 3'd3);
    issue(1, 2'b11, 32'h0C); chk_arch("bp_skip", 3'd0);
    issue(0, 2'b11, 32'h0C); chk_arch("bp_rearm", 3'd3);
    issue(1, 2'b00, 32'h10); chk_arch("bp_leave", 3'd0);
    bp_en = 1'b0;

    // wrap-around of pc + 4
    j_target = 32'hFFFF_FFFF;
    issue(0, 2'b11, 32'hFFFF_FFFC); chk_arch("wrap_pre", 3'd0);
    chk("wrap_pre_pc4", pc4, 32'h0);
    chk("wrap_pre_rom_addr", {26'd0, rom_addr}, 32'h3F);
    issue(0, 2'b00, 32'h0); chk_arch("wrap", 3'd0);
    chk("wrap_pc4", pc4, 32'h4);

    // mode change while an instruction is in flight
    exp_q.push_back(m_pc);
    pcsource = 2'b00; run = 1'b1; tick = 1'b1; clk1();
    tick = 1'b0; run = 1'b0; clk1(); clk1();
    m_pc = 32'h4; m_ret = m_ret + 16'd1;
    chk_arch("mode_change", 3'd0);

    // retire counter saturation
    force dut.retired_q = 16'hFFFE;
    clk1();
    release dut.retired_q;
    m_ret = 16'hFFFE;
    issue(0, 2'b00, 32'h8); chk_arch("sat_reach", 3'd0);
    issue(0, 2'b00, 32'hC); chk_arch("sat_hold", 3'd0);

    // ROM_LAT=3: reset in the middle of FETCH, then full latency
    rst = 1'b1; run = 1'b1; tick = 1'b0; pcsource = 2'b00;
    clk1();
    rst3 = 1'b0;
    tick = 1'b1; clk1(); tick = 1'b0; clk1();
    chk("l3_fetch_state", {29'd0, state_o3}, 32'd1);
    chk("l3_fetch_rom_en", {31'd0, rom_en3}, 32'd1);
    #2 rst3 = 1'b1;
    #1;
    chk("l3_rst_state", {29'd0, state_o3}, 32'd0);
    chk("l3_rst_rom_en", {31'd0, rom_en3}, 32'd0);
    chk("l3_rst_pc", pc3, 32'h0);
    chk("l3_rst_retired", {16'd0, retired3}, 32'd0);
    chk("l3_rst_halted", {31'd0, halted3}, 32'd0);
    repeat (5) begin
      tick = 1'b1; clk1();
      chk("l3_iv_in_reset", {31'd0, inst_valid3}, 32'd0);
    end
    tick = 1'b0;
    rst3 = 1'b0;
    tick = 1'b1; clk1(); tick = 1'b0;
    chk("l3_c1_state", {29'd0, state_o3}, 32'd1);
    clk1(); chk("l3_c2_state", {29'd0, state_o3}, 32'd1);
    clk1(); chk("l3_c3_state", {29'd0, state_o3}, 32'd1);
    chk("l3_c3_iv", {31'd0, inst_valid3}, 32'd0);
    clk1(); chk("l3_c4_iv", {31'd0, inst_valid3}, 32'd1);
    clk1();
    chk("l3_done_state", {29'd0, state_o3}, 32'd0);
    chk("l3_done_pc", pc3, 32'h4);
    chk("l3_done_retired", {16'd0, retired3}, 32'd1);

    chk("commits_outstanding", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
